// File: rtl/prot_status_monitor.sv
// ============================================================================
// Module      : prot_status_monitor
// Description : Debounced relay/fault monitor with trip counting, trip-rate
//               lockout and a small read-back register map.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prot_status_monitor #(
    parameter int FILTER_CYCLES = 4,
    parameter int WINDOW_CYCLES = 1000000,
    parameter int MAX_TRIPS     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        relay_en_in,
    input  logic        fault_in,
    input  logic        clear,
    input  logic        rd_en,
    input  logic [1:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        trip_irq,
    output logic        lockout,
    output logic        relay_permit
);

    localparam int c_FCNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam int c_WIN_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [c_FCNT_W-1:0] c_FCNT_MAX = c_FCNT_W'(FILTER_CYCLES - 1);
    localparam logic [c_WIN_W-1:0]  c_WIN_LAST = c_WIN_W'(WINDOW_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_ON      = 2'd1,
        ST_TRIPPED = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    logic [1:0] w_async;
    logic [1:0] w_filt;

    assign w_async = {fault_in, relay_en_in};

    // Bit 0 = relay enable, bit 1 = fault; each gets its own sync + debounce.
    for (genvar i = 0; i < 2; i++) begin : g_filt
        logic                r_meta;
        logic                r_sync;
        logic                r_filt;
        logic [c_FCNT_W-1:0] r_fcnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_meta <= 1'b0;
                r_sync <= 1'b0;
                r_filt <= 1'b0;
                r_fcnt <= '0;
            end else begin
                r_meta <= w_async[i];
                r_sync <= r_meta;
                if (r_sync != r_filt) begin
                    if (r_fcnt == c_FCNT_MAX) begin
                        r_filt <= r_sync;
                        r_fcnt <= '0;
                    end else begin
                        r_fcnt <= r_fcnt + 1'b1;
                    end
                end else begin
                    r_fcnt <= '0;
                end
            end
        end

        assign w_filt[i] = r_filt;
    end

    state_t              r_state;
    logic [15:0]         r_trip_count;
    logic [3:0]          r_win_trips;
    logic [15:0]         r_off_timer;
    logic [15:0]         r_last_off;
    logic [c_WIN_W-1:0]  r_win_cnt;
    logic                r_trip_irq;
    logic                r_rd_valid;
    logic [15:0]         r_rd_data;

    logic        w_relay_f;
    logic        w_fault_f;
    logic        w_wrap;
    logic        w_trip;
    logic        w_lock_hit;
    logic [3:0]  w_win_base;
    logic [3:0]  w_win_inc;
    logic [15:0] w_rd_mux;

    assign w_relay_f  = w_filt[0];
    assign w_fault_f  = w_filt[1];
    assign w_wrap     = (r_win_cnt == c_WIN_LAST);
    assign w_trip     = (r_state == ST_ON) && (w_fault_f || !w_relay_f);
    // A trip on the wrap cycle counts into the fresh window.
    assign w_win_base = w_wrap ? 4'd0 : r_win_trips;
    assign w_win_inc  = (w_win_base == 4'hF) ? 4'hF : w_win_base + 4'd1;
    assign w_lock_hit = (int'(w_win_inc) >= MAX_TRIPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_OFF;
            r_trip_count <= '0;
            r_win_trips  <= '0;
            r_off_timer  <= '0;
            r_last_off   <= '0;
            r_win_cnt    <= '0;
            r_trip_irq   <= 1'b0;
        end else if (clear) begin
            r_state      <= ST_OFF;
            r_trip_count <= '0;
            r_win_trips  <= '0;
            r_off_timer  <= '0;
            r_last_off   <= '0;
            r_win_cnt    <= '0;
            r_trip_irq   <= 1'b0;
        end else begin
            r_trip_irq  <= 1'b0;
            r_win_cnt   <= w_wrap ? '0 : r_win_cnt + 1'b1;
            r_win_trips <= w_win_base;
            case (r_state)
                ST_OFF: begin
                    if (w_relay_f && !w_fault_f) r_state <= ST_ON;
                end
                ST_ON: begin
                    if (w_trip) begin
                        r_trip_irq   <= 1'b1;
                        r_trip_count <= (r_trip_count == 16'hFFFF) ? 16'hFFFF
                                                                   : r_trip_count + 16'd1;
                        r_win_trips  <= w_win_inc;
                        r_off_timer  <= '0;
                        r_state      <= w_lock_hit ? ST_LOCKOUT : ST_TRIPPED;
                    end
                end
                ST_TRIPPED: begin
                    if (w_relay_f && !w_fault_f) begin
                        r_last_off <= r_off_timer;
                        r_state    <= ST_ON;
                    end else if (r_off_timer != 16'hFFFF) begin
                        r_off_timer <= r_off_timer + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (rd_addr)
            2'd0:    w_rd_mux = {12'b0, r_state, w_fault_f, w_relay_f};
            2'd1:    w_rd_mux = r_trip_count;
            2'd2:    w_rd_mux = r_last_off;
            default: w_rd_mux = {12'b0, r_win_trips};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= rd_en;
            r_rd_data  <= rd_en ? w_rd_mux : 16'd0;
        end
    end

    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign trip_irq     = r_trip_irq;
    assign lockout      = (r_state == ST_LOCKOUT);
    assign relay_permit = (r_state != ST_LOCKOUT);

endmodule

`default_nettype wire

// File: doc/prot_status_monitor.md
PROT_STATUS_MONITOR -- requirements
Module: prot_status_monitor

Interface
REQ-001 SHALL have parameter FILTER_CYCLES, default 4: cycles an input must be stable before its filtered value updates.
REQ-002 SHALL have parameter WINDOW_CYCLES, default 1000000: length of the trip-rate window, in clk cycles.
REQ-003 SHALL have parameter MAX_TRIPS, default 4: number of trips within one window that forces lockout.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 relay_en_in  input  1  protection relay enable from the protection driver, asynchronous to clk.
REQ-007 fault_in  input  1  fault indication from the protection driver, asynchronous to clk.
REQ-008 clear  input  1  single-cycle pulse; clears counters and lockout.
REQ-009 rd_en  input  1  single-cycle register read request.
REQ-010 rd_addr  input  2  register select, sampled with rd_en.
REQ-011 rd_data  output  16  read data, valid while rd_valid=1.
REQ-012 rd_valid  output  1  read response strobe.
REQ-013 trip_irq  output  1  one-cycle pulse per counted trip.
REQ-014 lockout  output  1  latched over-rate fault.
REQ-015 relay_permit  output  1  permission for the relay; equals !lockout.

Function
REQ-016 Each async input SHALL pass through a 2-flop synchronizer, then a debounce filter.
REQ-017 The filtered value SHALL update only after the synchronized value has differed from it for FILTER_CYCLES consecutive cycles; any mismatch break restarts the count.
REQ-018 Total input-to-filtered latency SHALL be 2+FILTER_CYCLES cycles.
REQ-019 The FSM SHALL have states OFF=0, ON=1, TRIPPED=2 and LOCKOUT=3.
REQ-020 OFF->ON SHALL occur when relay_f=1 and fault_f=0.
REQ-021 ON->TRIPPED SHALL occur on fault_f=1 or relay_f=0, counted as one trip: trip_irq pulses 1 cycle, trip_count +1 saturating at 0xFFFF, win_trips +1 saturating at 15, off_timer cleared.
REQ-022 In TRIPPED, off_timer SHALL increment each cycle, saturating at 0xFFFF.
REQ-023 TRIPPED->ON SHALL occur when relay_f=1 and fault_f=0; on that transition off_timer is copied to last_off_time.
REQ-024 If the trip makes win_trips reach MAX_TRIPS, next state SHALL be LOCKOUT instead of TRIPPED.
REQ-025 LOCKOUT SHALL be left only via clear, to OFF; lockout=1 exactly while in LOCKOUT.
REQ-026 A window counter SHALL count 0..WINDOW_CYCLES-1 free-running; at wrap, win_trips resets to 0.
REQ-027 If a trip coincides with a window wrap, win_trips SHALL become 1.
REQ-028 clear SHALL zero trip_count, win_trips, last_off_time and the window counter and go to OFF.
REQ-029 If clear coincides with a trip, clear SHALL win: the trip is not counted and trip_irq stays 0.
REQ-030 A read SHALL assert rd_valid exactly 1 cycle after rd_en, for 1 cycle.
REQ-031 Read data SHALL be captured in the rd_en cycle; back-to-back rd_en SHALL be served every cycle.
REQ-032 Read map: addr0 = {12'b0, state[1:0], fault_f, relay_f}; addr1 = trip_count; addr2 = last_off_time; addr3 = {12'b0, win_trips}.
REQ-033 rd_data SHALL be 0 whenever rd_valid=0.

Reset
REQ-034 rst_n=0 SHALL asynchronously force the following: state OFF; all counters, filters and synchronizers 0; trip_irq=0, lockout=0, rd_valid=0, rd_data=0, relay_permit=1.
REQ-035 Reset mid-operation (including in LOCKOUT) SHALL discard all history; after release, the filters need 2+FILTER_CYCLES cycles before any transition.

Verification
REQ-036 relay_en_in=1 glitch of 3 cycles (FILTER=4) -> state stays OFF; a 6-cycle high -> ON at cycle 6 after the edge.
REQ-037 In ON, assert fault_in, hold 100 cycles, release; relay_en_in=1 -> one trip_irq pulse, addr1=1, addr2 within ±2 of 100.
REQ-038 4 trips inside one window (WINDOW=1000) -> 4th trip enters LOCKOUT, lockout=1, relay_permit=0; pulse clear -> OFF, addr1=0.
REQ-039 Trip on the exact window-wrap cycle -> addr3 reads 1; 3 trips, wrap, 1 trip -> no lockout.
REQ-040 clear and trip in the same cycle -> trip_irq=0, addr1=0; rst_n low while in LOCKOUT -> all outputs at REQ-034 values immediately.
